// File: rtl/lane_seq_gen2_if.sv
// Instruction, VRF-read, exe, ext and VRF-write signals of one lane sequencer.
// The core side drives through the master modport and the sequencer sits on the slave modport.
interface lane_seq_gen2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMS      = 4
);
  localparam int ELEM_B = $clog2(ELEMS);

  logic                  instr_valid_i;
  logic                  instr_ready_o;
  logic                  instr_piped_i;
  logic                  instr_ext_i;
  logic                  instr_vm_i;
  logic [ELEM_B:0]       vl_i;
  logic [ELEMS-1:0]      mask_bits_i;
  logic                  rd_req_o;
  logic                  rd_op_ready_i;
  logic                  exe_valid_o;
  logic [ELEM_B-1:0]     vs_elem_cnt_o;
  logic [DATA_WIDTH-1:0] alu_wdata_i;
  logic [ELEM_B-1:0]     ext_vs_elem_i;
  logic [ELEM_B-1:0]     ext_vd_elem_i;
  logic                  ext_wr_en_i;
  logic [DATA_WIDTH-1:0] ext_wdata_i;
  logic                  ext_done_i;
  logic                  wr_en_o;
  logic [ELEM_B-1:0]     vd_elem_cnt_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  done_o;

  modport master (
    output instr_valid_i, instr_piped_i, instr_ext_i, instr_vm_i, vl_i, mask_bits_i,
           rd_op_ready_i, alu_wdata_i, ext_vs_elem_i, ext_vd_elem_i, ext_wr_en_i,
           ext_wdata_i, ext_done_i,
    input  instr_ready_o, rd_req_o, exe_valid_o, vs_elem_cnt_o, wr_en_o, vd_elem_cnt_o,
           wdata_o, done_o
  );

  modport slave (
    input  instr_valid_i, instr_piped_i, instr_ext_i, instr_vm_i, vl_i, mask_bits_i,
           rd_op_ready_i, alu_wdata_i, ext_vs_elem_i, ext_vd_elem_i, ext_wr_en_i,
           ext_wdata_i, ext_done_i,
    output instr_ready_o, rd_req_o, exe_valid_o, vs_elem_cnt_o, wr_en_o, vd_elem_cnt_o,
           wdata_o, done_o
  );
endinterface

// File: rtl/lane_seq_gen2.sv
// Per-lane element sequencer: one instruction at a time, streams vl elements to the exe unit,
// tracks them through a latency-selectable delay line and issues masked VRF writebacks.
module lane_seq_gen2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMS      = 4,
  parameter int PIPE_ST    = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  lane_seq_gen2_if.slave bus
);
  localparam int ELEM_B = $clog2(ELEMS);
  localparam logic [ELEM_B:0]   VL_MAX  = (ELEM_B+1)'(ELEMS);
  localparam logic [ELEM_B:0]   VL_ONE  = (ELEM_B+1)'(1);
  localparam logic [ELEM_B-1:0] IDX_ONE = ELEM_B'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXE,
    ST_DRAIN,
    ST_EXT,
    ST_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic                         piped_q, piped_d;
  logic                         ext_q, ext_d;
  logic                         vm_q, vm_d;
  logic [ELEM_B:0]              vl_q, vl_d;
  logic [ELEMS-1:0]             mask_q, mask_d;
  logic [ELEM_B-1:0]            issue_idx_q, issue_idx_d;
  logic [PIPE_ST-1:0]           dl_valid_q, dl_valid_d;
  logic [PIPE_ST-1:0][ELEM_B-1:0] dl_idx_q, dl_idx_d;

  logic              issue;
  logic              tap_valid;
  logic [ELEM_B-1:0] tap_idx;
  logic              alu_wr_en;
  logic              pending;

  // The tap stage is the last stage for piped ops and stage 0 otherwise; only stages in
  // front of the tap can still hold elements that have not been written back.
  always_comb begin
    tap_valid = piped_q ? dl_valid_q[PIPE_ST-1] : dl_valid_q[0];
    tap_idx   = piped_q ? dl_idx_q[PIPE_ST-1]   : dl_idx_q[0];
    alu_wr_en = tap_valid && (vm_q || mask_q[tap_idx]);
    pending   = piped_q && (|dl_valid_q[PIPE_ST-2:0]);
  end

  always_comb begin
    state_d     = state_q;
    piped_d     = piped_q;
    ext_d       = ext_q;
    vm_d        = vm_q;
    vl_d        = vl_q;
    mask_d      = mask_q;
    issue_idx_d = issue_idx_q;
    issue       = 1'b0;

    bus.instr_ready_o = 1'b0;
    bus.rd_req_o      = 1'b0;
    bus.exe_valid_o   = 1'b0;
    bus.vs_elem_cnt_o = '0;
    bus.done_o        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.instr_ready_o = 1'b1;
        if (bus.instr_valid_i) begin
          piped_d     = bus.instr_piped_i;
          ext_d       = bus.instr_ext_i;
          vm_d        = bus.instr_vm_i;
          mask_d      = bus.mask_bits_i;
          vl_d        = (bus.vl_i > VL_MAX) ? VL_MAX : bus.vl_i;
          issue_idx_d = '0;
          state_d     = (bus.vl_i == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        bus.rd_req_o = 1'b1;
        if (bus.rd_op_ready_i) begin
          state_d = ext_q ? ST_EXT : ST_EXE;
        end
      end
      ST_EXE: begin
        issue             = 1'b1;
        bus.exe_valid_o   = 1'b1;
        bus.vs_elem_cnt_o = issue_idx_q;
        issue_idx_d       = issue_idx_q + IDX_ONE;
        if ({1'b0, issue_idx_q} == (vl_q - VL_ONE)) begin
          issue_idx_d = '0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pending) begin
          state_d = ST_DONE;
        end
      end
      ST_EXT: begin
        bus.vs_elem_cnt_o = bus.ext_vs_elem_i;
        if (bus.ext_done_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ALU ops never advance valid past stage 0, so the line empties as soon as the tap is written.
  always_comb begin
    dl_valid_d    = '0;
    dl_idx_d      = '0;
    dl_valid_d[0] = issue;
    dl_idx_d[0]   = issue_idx_q;
    for (int i = 1; i < PIPE_ST; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1] && piped_q;
      dl_idx_d[i]   = dl_idx_q[i-1];
    end
  end

  always_comb begin
    if (state_q == ST_EXT) begin
      bus.wr_en_o       = bus.ext_wr_en_i;
      bus.vd_elem_cnt_o = bus.ext_vd_elem_i;
      bus.wdata_o       = bus.ext_wdata_i;
    end else begin
      bus.wr_en_o       = alu_wr_en;
      bus.vd_elem_cnt_o = tap_valid ? tap_idx : '0;
      bus.wdata_o       = alu_wr_en ? bus.alu_wdata_i : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      piped_q     <= 1'b0;
      ext_q       <= 1'b0;
      vm_q        <= 1'b0;
      vl_q        <= '0;
      mask_q      <= '0;
      issue_idx_q <= '0;
      dl_valid_q  <= '0;
      dl_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      piped_q     <= piped_d;
      ext_q       <= ext_d;
      vm_q        <= vm_d;
      vl_q        <= vl_d;
      mask_q      <= mask_d;
      issue_idx_q <= issue_idx_d;
      dl_valid_q  <= dl_valid_d;
      dl_idx_q    <= dl_idx_d;
    end
  end
endmodule

// File: tb/tb_lane_seq_gen2.sv
// Directed bench for lane_seq_gen2: each instruction runs on a cycle grid counted from its
// accept cycle (0), and the logged timing is compared with hand-computed values.
module tb_lane_seq_gen2;
  localparam int DATA_WIDTH = 32;
  localparam int ELEMS      = 4;
  localparam int PIPE_ST    = 4;

  logic clk_i = 1'b0;
  logic reset_i;

  always #5 clk_i = ~clk_i;

  lane_seq_gen2_if #(.DATA_WIDTH(DATA_WIDTH), .ELEMS(ELEMS)) bus ();

  lane_seq_gen2 #(
    .DATA_WIDTH(DATA_WIDTH),
    .ELEMS     (ELEMS),
    .PIPE_ST   (PIPE_ST)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int total;
  int bad;

  int rd_cnt, exe_cnt, first_exe, wr_cnt, first_wr, last_wr, done_cnt, done_cyc;
  int vs_bad, ready_after, ready0, vs_at5;
  logic [ELEMS-1:0] wr_map;
  logic [31:0]      first_data;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction; ext ops get write pulses at cycles 2 (still READ), 4 and 6 and done at 8.
  task automatic apply_stimulus(input logic piped, input logic ext, input logic vm,
                                input logic [2:0] vl, input logic [3:0] mask,
                                input int reset_cyc, input int max_c);
    bit stop;
    rd_cnt = 0; exe_cnt = 0; first_exe = -1; wr_cnt = 0; first_wr = -1; last_wr = -1;
    done_cnt = 0; done_cyc = -1; vs_bad = 0; ready_after = -1; ready0 = -1; vs_at5 = -1;
    wr_map = '0; first_data = '0;
    bus.instr_piped_i = piped;
    bus.instr_ext_i   = ext;
    bus.instr_vm_i    = vm;
    bus.vl_i          = vl;
    bus.mask_bits_i   = mask;
    for (int c = 0; c <= max_c; c++) begin
      stop = 1'b0;
      bus.instr_valid_i = (c == 0);
      bus.rd_op_ready_i = (c >= 2);
      bus.alu_wdata_i   = 32'hA000_0000 | 32'(c);
      bus.ext_wr_en_i   = ext && (c == 2 || c == 4 || c == 6);
      bus.ext_vd_elem_i = (c == 4) ? 2'd1 : 2'd3;
      bus.ext_vs_elem_i = 2'(c);
      bus.ext_wdata_i   = 32'hE000_0000 | 32'(c);
      bus.ext_done_i    = ext && (c == 8);
      reset_i           = (c == reset_cyc);
      #2;
      if (c == 0) ready0 = int'(bus.instr_ready_o);
      if (c == 5) vs_at5 = int'(bus.vs_elem_cnt_o);
      if (bus.rd_req_o) rd_cnt++;
      if (bus.exe_valid_o) begin
        if (int'(bus.vs_elem_cnt_o) != exe_cnt) vs_bad++;
        exe_cnt++;
        if (first_exe < 0) first_exe = c;
      end
      if (bus.wr_en_o) begin
        wr_cnt++;
        wr_map[bus.vd_elem_cnt_o] = 1'b1;
        if (first_wr < 0) begin
          first_wr   = c;
          first_data = bus.wdata_o;
        end
        last_wr = c;
      end
      if ((reset_cyc >= 0 && c == reset_cyc + 1) ||
          (reset_cyc < 0 && done_cyc >= 0 && c == done_cyc + 1)) begin
        ready_after = int'(bus.instr_ready_o);
        stop = (reset_cyc < 0);
      end
      if (bus.done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk_i);
      #1;
      if (stop) break;
    end
    bus.instr_valid_i = 1'b0;
    bus.ext_wr_en_i   = 1'b0;
    bus.ext_done_i    = 1'b0;
    reset_i           = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_i = 1'b1;
    bus.instr_valid_i = 1'b0; bus.instr_piped_i = 1'b0; bus.instr_ext_i = 1'b0;
    bus.instr_vm_i = 1'b1; bus.vl_i = '0; bus.mask_bits_i = '0; bus.rd_op_ready_i = 1'b0;
    bus.alu_wdata_i = '0; bus.ext_vs_elem_i = '0; bus.ext_vd_elem_i = '0;
    bus.ext_wr_en_i = 1'b0; bus.ext_wdata_i = '0; bus.ext_done_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    #2;
    check_output("rst_ready", 32'(bus.instr_ready_o), 1);
    check_output("rst_rd_req", 32'(bus.rd_req_o), 0);
    check_output("rst_exe_valid", 32'(bus.exe_valid_o), 0);
    check_output("rst_wr_en", 32'(bus.wr_en_o), 0);
    check_output("rst_done", 32'(bus.done_o), 0);
    check_output("rst_wdata", bus.wdata_o, 0);
    @(posedge clk_i);
    #1;

    // ALU, unmasked, vl=4
    apply_stimulus(1'b0, 1'b0, 1'b1, 3'd4, 4'b0000, -1, 30);
    check_output("alu_accept_ready", ready0, 1);
    check_output("alu_rd_req_cycles", rd_cnt, 2);
    check_output("alu_first_exe", first_exe, 3);
    check_output("alu_exe_cnt", exe_cnt, 4);
    check_output("alu_vs_order", vs_bad, 0);
    check_output("alu_wr_cnt", wr_cnt, 4);
    check_output("alu_wr_map", 32'(wr_map), 32'hF);
    check_output("alu_first_wr", first_wr, 4);
    check_output("alu_last_wr", last_wr, 7);
    check_output("alu_first_data", first_data, 32'hA000_0004);
    check_output("alu_done_cyc", done_cyc, 8);
    check_output("alu_done_cnt", done_cnt, 1);
    check_output("alu_ready_after", ready_after, 1);

    // Piped, vl=3
    apply_stimulus(1'b1, 1'b0, 1'b1, 3'd3, 4'b0000, -1, 30);
    check_output("pip_exe_cnt", exe_cnt, 3);
    check_output("pip_wr_cnt", wr_cnt, 3);
    check_output("pip_wr_map", 32'(wr_map), 32'h7);
    check_output("pip_first_wr", first_wr, 7);
    check_output("pip_last_wr", last_wr, 9);
    check_output("pip_first_data", first_data, 32'hA000_0007);
    check_output("pip_done_cyc", done_cyc, 10);
    check_output("pip_done_cnt", done_cnt, 1);

    // ALU, masked 0101, vl=4
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'd4, 4'b0101, -1, 30);
    check_output("msk_exe_cnt", exe_cnt, 4);
    check_output("msk_wr_cnt", wr_cnt, 2);
    check_output("msk_wr_map", 32'(wr_map), 32'h5);
    check_output("msk_first_wr", first_wr, 4);
    check_output("msk_last_wr", last_wr, 6);
    check_output("msk_done_cyc", done_cyc, 8);

    // vl=0 goes straight to DONE
    apply_stimulus(1'b0, 1'b0, 1'b1, 3'd0, 4'b0000, -1, 30);
    check_output("vl0_rd_req", rd_cnt, 0);
    check_output("vl0_exe_cnt", exe_cnt, 0);
    check_output("vl0_wr_cnt", wr_cnt, 0);
    check_output("vl0_done_cyc", done_cyc, 1);
    check_output("vl0_ready_after", ready_after, 1);

    // vl above ELEMS is clamped
    apply_stimulus(1'b0, 1'b0, 1'b1, 3'd7, 4'b0000, -1, 30);
    check_output("clamp_exe_cnt", exe_cnt, 4);
    check_output("clamp_wr_map", 32'(wr_map), 32'hF);
    check_output("clamp_done_cyc", done_cyc, 8);

    // Ext op: writes mirror ext inputs only while in EXT
    apply_stimulus(1'b0, 1'b1, 1'b1, 3'd4, 4'b0000, -1, 30);
    check_output("ext_rd_req", rd_cnt, 2);
    check_output("ext_exe_cnt", exe_cnt, 0);
    check_output("ext_wr_cnt", wr_cnt, 2);
    check_output("ext_wr_map", 32'(wr_map), 32'hA);
    check_output("ext_first_wr", first_wr, 4);
    check_output("ext_first_data", first_data, 32'hE000_0004);
    check_output("ext_vs_pass", vs_at5, 1);
    check_output("ext_done_cyc", done_cyc, 9);
    check_output("ext_done_cnt", done_cnt, 1);

    // Reset during EXE of a piped op
    apply_stimulus(1'b1, 1'b0, 1'b1, 3'd4, 4'b0000, 4, 16);
    check_output("rst_mid_exe_cnt", exe_cnt, 2);
    check_output("rst_mid_ready", ready_after, 1);
    check_output("rst_mid_wr_cnt", wr_cnt, 0);
    check_output("rst_mid_done_cnt", done_cnt, 0);

    // A normal op still works after the abort
    apply_stimulus(1'b0, 1'b0, 1'b1, 3'd2, 4'b0000, -1, 30);
    check_output("post_rst_wr_map", 32'(wr_map), 32'h3);
    check_output("post_rst_done_cyc", done_cyc, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
